wormhole_output_allocator: RTL and testbench
============================================

// Module: wormhole_output_allocator
// PURPOSE
//  Per-output-port switch allocator for the NoC router, one instance per output.
//  Shares one output link among NUM_INPUTS input buffers with round-robin fairness.
//  Holds the link for a whole packet (head..tail) and gates sends on downstream credits.
//  The winning flit is registered onto the output link.
// PARAMETERS
//  NUM_INPUTS    5   number of requesting input ports
//  FLIT_WIDTH    32  flit payload width
//  DEST_WIDTH    6   dest field width ({tid,tdest})
//  CREDIT_DEPTH  1   downstream buffer depth = initial credit count (>=1)
// PORTS
//  clk             in   1                      NoC clock
//  rst_n           in   1                      async active-low reset
//  req             in   NUM_INPUTS             input i holds a flit routed to this output
//  is_tail_in      in   NUM_INPUTS             flit at input i is a packet tail
//  data_in         in   NUM_INPUTS*FLIT_WIDTH  flit payload per input
//  dest_in         in   NUM_INPUTS*DEST_WIDTH  dest per input
//  grant           out  NUM_INPUTS             one-hot pop strobe to input buffer (combinational)
//  data_out        out  FLIT_WIDTH             registered flit to link
//  dest_out        out  DEST_WIDTH             registered dest
//  is_tail_out     out  1                      registered tail flag
//  send_out        out  1                      flit valid on link, 1-cycle pulse per flit
//  credit_in       in   1                      downstream returned one buffer slot
//  locked          out  1                      packet in flight (state==LOCKED)
//  credit_overflow out  1                      sticky: credit_in with counter at CREDIT_DEPTH
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, owner=0, credits=CREDIT_DEPTH; data_out/dest_out/
//   is_tail_out/send_out/locked/credit_overflow=0. Mid-packet reset drops the lock.
//  CNT_W=$clog2(CREDIT_DEPTH+1); credits unsigned, never below 0 or above CREDIT_DEPTH.
//  fire = |grant. grant is never asserted when credits==0.
//  IDLE: if credits>0 and |req, winner = first i with req[i] scanning rr_ptr, rr_ptr+1,
//   ... mod NUM_INPUTS; grant[winner]=1 same cycle.
//   fire & is_tail_in[winner] (single-flit packet): stay IDLE, rr_ptr<=winner+1 mod N.
//   fire & !tail: owner<=winner, go LOCKED.
//  LOCKED: grant[owner]=req[owner] & credits>0; all other grants 0 (other reqs ignored).
//   fire & is_tail_in[owner]: go IDLE, rr_ptr<=owner+1 mod N. req[owner] low: hold lock.
//  Output register: on fire, data_out/dest_out/is_tail_out <= winner's inputs, send_out<=1
//   next cycle; no fire -> send_out<=0, data/dest/tail hold last value.
//  Latency: grant cycle T -> send_out high at T+1. Back-to-back flits: 1 per cycle.
//  Credits: next = credits - fire + credit_in; fire and credit_in together -> unchanged.
//   credit_in at credits==CREDIT_DEPTH with no fire: credits hold, credit_overflow<=1
//   (sticky until reset).
//  credits==0 with credit_in the same cycle: no grant this cycle (uses registered count).
//  locked = (state==LOCKED), registered.
// TESTING
//  T1 reset: hold rst_n=0, drive req=5'b11111 -> grant=0, send_out=0,
//   internal credits=CREDIT_DEPTH, locked=0.
//  T2 round-robin: CREDIT_DEPTH=4, credit_in tied to send_out; req=5'b00101, every flit
//   tail -> grant order 0,2,0,2; send_out pulses with matching data one cycle later.
//  T3 wormhole lock: input 1 sends 3-flit packet (H,B,T) while req[3]=1 -> grants 1,1,1
//   then 3; locked=1 from after H through T; req[1] gap mid-packet -> no grant to 3.
//  T4 credit stall: CREDIT_DEPTH=2, no credit_in, 4-flit packet -> 2 grants then stall;
//   one credit_in -> exactly 1 more grant; simultaneous fire+credit_in keeps count.
//  T5 overflow: idle, credits full, pulse credit_in -> credit_overflow=1 and stays 1;
//   credits remain CREDIT_DEPTH.
//  T6 reset mid-packet: assert rst_n=0 after head flit -> locked=0, send_out=0 at once;
//   after release req=5'b10000 -> grant[4] (rr_ptr=0 scan).

Source files
------------

// File: rtl/wormhole_output_allocator_if.sv
// Bundle of signals between one output allocator and the router around it.
//   req/is_tail_in/data_in/dest_in : per-input flit offered to this output
//   grant                          : one-hot pop strobe back to the input buffers
//   data_out/dest_out/is_tail_out  : registered flit on the output link
//   send_out                       : flit valid on the link, one pulse per flit
//   credit_in                      : downstream freed one buffer slot
//   locked/credit_overflow         : status
// The 'slave' modport is the allocator; 'master' is the surrounding router or bench.
interface wormhole_output_allocator_if #(
   parameter int NUM_INPUTS = 5,
   parameter int FLIT_WIDTH = 32,
   parameter int DEST_WIDTH = 6
);
   logic [NUM_INPUTS-1:0]                 req;
   logic [NUM_INPUTS-1:0]                 is_tail_in;
   logic [NUM_INPUTS-1:0][FLIT_WIDTH-1:0] data_in;
   logic [NUM_INPUTS-1:0][DEST_WIDTH-1:0] dest_in;
   logic [NUM_INPUTS-1:0]                 grant;
   logic [FLIT_WIDTH-1:0]                 data_out;
   logic [DEST_WIDTH-1:0]                 dest_out;
   logic                                  is_tail_out;
   logic                                  send_out;
   logic                                  credit_in;
   logic                                  locked;
   logic                                  credit_overflow;

   modport master (
      output req, is_tail_in, data_in, dest_in, credit_in,
      input  grant, data_out, dest_out, is_tail_out, send_out, locked, credit_overflow
   );

   modport slave (
      input  req, is_tail_in, data_in, dest_in, credit_in,
      output grant, data_out, dest_out, is_tail_out, send_out, locked, credit_overflow
   );
endinterface

// File: rtl/wormhole_output_allocator.sv
// Per-output switch allocator: round-robin among inputs, holds the link for a
// whole wormhole packet (head..tail), and only grants when downstream has credit.
// The granted flit is registered onto the output link one cycle after the grant.
// Ports: clk, rst_n (async active-low), bus (wormhole_output_allocator_if.slave).

// Per-input grant qualification: the arbiter picks a candidate, the lane turns it
// into a pop strobe only when that input really holds a flit and a credit exists.
module wormhole_output_allocator_lane (
   input  logic chosen,
   input  logic req,
   input  logic can_send,
   output logic grant
);
   assign grant = chosen & req & can_send;
endmodule

module wormhole_output_allocator #(
   parameter int NUM_INPUTS   = 5,
   parameter int FLIT_WIDTH   = 32,
   parameter int DEST_WIDTH   = 6,
   parameter int CREDIT_DEPTH = 1
) (
   input logic                        clk,
   input logic                        rst_n,
   wormhole_output_allocator_if.slave bus
);
   localparam int PTR_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
   localparam int IDX_W = PTR_W + 1;
   localparam int CNT_W = $clog2(CREDIT_DEPTH + 1);
   localparam logic [IDX_W-1:0] N_IDX    = IDX_W'(NUM_INPUTS);
   localparam logic [PTR_W-1:0] LAST     = PTR_W'(NUM_INPUTS - 1);
   localparam logic [CNT_W-1:0] CRED_MAX = CNT_W'(CREDIT_DEPTH);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t                 state;
   logic [PTR_W-1:0]       rr_ptr;
   logic [PTR_W-1:0]       owner;
   logic [CNT_W-1:0]       credits;

   logic [IDX_W-1:0]       idx;
   logic [PTR_W-1:0]       scan;
   logic                   found;
   logic [PTR_W-1:0]       winner;
   logic [NUM_INPUTS-1:0]  sel;
   logic [NUM_INPUTS-1:0]  grant_w;
   logic                   can_send;
   logic                   fire;
   logic                   tail_sel;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      next_ptr = (p == LAST) ? '0 : p + 1'b1;
   endfunction

   // Round-robin scan starting at rr_ptr; the wrap is a subtract rather than a
   // modulo so non-power-of-two input counts stay cheap.
   always_comb begin
      found = 1'b0;
      scan  = rr_ptr;
      idx   = '0;
      for (int k = 0; k < NUM_INPUTS; k++) begin
         idx = {1'b0, rr_ptr} + IDX_W'(k);
         if (idx >= N_IDX) idx = idx - N_IDX;
         if (!found && bus.req[idx[PTR_W-1:0]]) begin
            found = 1'b1;
            scan  = idx[PTR_W-1:0];
         end
      end
   end

   // While a packet is in flight only the owner may use the link, even if its
   // buffer is momentarily empty (the lock is held across request gaps).
   assign winner = (state == LOCKED) ? owner : scan;

   always_comb begin
      sel = '0;
      if (state == LOCKED || found) sel[winner] = 1'b1;
   end

   // Uses the registered credit count only, so a credit returning this cycle
   // cannot enable a grant until next cycle. Reset also forces the grant low.
   assign can_send = rst_n && (credits != '0);

   for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lane
      wormhole_output_allocator_lane u_lane (
         .chosen   (sel[i]),
         .req      (bus.req[i]),
         .can_send (can_send),
         .grant    (grant_w[i])
      );
   end

   assign bus.grant = grant_w;
   assign fire      = |grant_w;
   assign tail_sel  = bus.is_tail_in[winner];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state               <= IDLE;
         rr_ptr              <= '0;
         owner               <= '0;
         credits             <= CRED_MAX;
         bus.data_out        <= '0;
         bus.dest_out        <= '0;
         bus.is_tail_out     <= 1'b0;
         bus.send_out        <= 1'b0;
         bus.locked          <= 1'b0;
         bus.credit_overflow <= 1'b0;
      end else begin
         // Output link register: payload holds its last value between flits.
         bus.send_out <= fire;
         if (fire) begin
            bus.data_out    <= bus.data_in[winner];
            bus.dest_out    <= bus.dest_in[winner];
            bus.is_tail_out <= tail_sel;
         end

         // A send and a returned credit in the same cycle cancel out.
         case ({fire, bus.credit_in})
            2'b10:   credits <= credits - 1'b1;
            2'b01: begin
               if (credits == CRED_MAX) bus.credit_overflow <= 1'b1;
               else                     credits <= credits + 1'b1;
            end
            default: ;
         endcase

         case (state)
            IDLE: begin
               if (fire) begin
                  if (tail_sel) begin
                     rr_ptr <= next_ptr(winner);
                  end else begin
                     owner      <= winner;
                     state      <= LOCKED;
                     bus.locked <= 1'b1;
                  end
               end
            end
            LOCKED: begin
               if (fire && tail_sel) begin
                  state      <= IDLE;
                  bus.locked <= 1'b0;
                  rr_ptr     <= next_ptr(owner);
               end
            end
            default: begin
               state      <= IDLE;
               bus.locked <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_wormhole_output_allocator.sv
// Scoreboard bench for wormhole_output_allocator (5 inputs, CREDIT_DEPTH=2).
// Each scenario walks a table of per-cycle stimulus rows with the expected winner;
// the expected link flit is queued when driven and popped when send_out fires.
module tb_wormhole_output_allocator;
   localparam int N  = 5;
   localparam int FW = 32;
   localparam int DW = 6;
   localparam int CD = 2;

   typedef struct packed {
      logic [N-1:0] r;
      logic [N-1:0] t;
      logic         c;
      int           e;
   } row_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic tie = 1'b0;
   logic credit_drv = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;
   logic [FW+DW:0] sb[$];

   wormhole_output_allocator_if #(.NUM_INPUTS(N), .FLIT_WIDTH(FW), .DEST_WIDTH(DW)) bus ();

   wormhole_output_allocator #(
      .NUM_INPUTS(N), .FLIT_WIDTH(FW), .DEST_WIDTH(DW), .CREDIT_DEPTH(CD)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   assign bus.credit_in = tie ? bus.send_out : credit_drv;

   function automatic logic [N-1:0] oh(input int e);
      logic [N-1:0] v;
      v = '0;
      if (e >= 0) v[e] = 1'b1;
      return v;
   endfunction

   // Link monitor: every send must match the oldest queued expectation.
   always @(negedge clk) begin
      if (bus.send_out) begin
         logic [FW+DW:0] exp_f;
         n_checks++;
         if (sb.size() == 0) begin
            n_errors++;
            $display("FAIL link_unexpected_send: got %h want no send",
                     {bus.data_out, bus.dest_out, bus.is_tail_out});
         end else begin
            exp_f = sb.pop_front();
            if ({bus.data_out, bus.dest_out, bus.is_tail_out} !== exp_f) begin
               n_errors++;
               $display("FAIL link_flit: got %h want %h",
                        {bus.data_out, bus.dest_out, bus.is_tail_out}, exp_f);
            end
         end
      end
   end

   // Drive one cycle of stimulus after the clock edge, queue the flit the row
   // expects to win, and return the grant seen mid-cycle.
   task automatic step(input row_t rw, output logic [N-1:0] g);
      @(posedge clk);
      #1;
      bus.req        = rw.r;
      bus.is_tail_in = rw.t;
      credit_drv     = rw.c;
      for (int i = 0; i < N; i++) begin
         bus.data_in[i] = $urandom;
         bus.dest_in[i] = DW'($urandom);
      end
      if (rw.e >= 0) sb.push_back({bus.data_in[rw.e], bus.dest_in[rw.e], rw.t[rw.e]});
      @(negedge clk);
      g = bus.grant;
   endtask

   task automatic test_reset();
      rst_n          = 1'b0;
      #1;
      bus.req        = 5'b11111;
      bus.is_tail_in = '0;
      bus.data_in    = '0;
      bus.dest_in    = '0;
      repeat (2) @(negedge clk);
      n_checks += 5;
      if (bus.grant !== 5'b0) begin n_errors++; $display("FAIL reset_grant: got %b want 00000", bus.grant); end
      if (bus.send_out !== 1'b0) begin n_errors++; $display("FAIL reset_send: got %b want 0", bus.send_out); end
      if (dut.credits !== 2'(CD)) begin n_errors++; $display("FAIL reset_credits: got %0d want %0d", dut.credits, CD); end
      if (bus.locked !== 1'b0) begin n_errors++; $display("FAIL reset_locked: got %b want 0", bus.locked); end
      if (bus.credit_overflow !== 1'b0) begin n_errors++; $display("FAIL reset_overflow: got %b want 0", bus.credit_overflow); end
      bus.req = '0;
      rst_n   = 1'b1;
   endtask

   task automatic test_round_robin();
      row_t rows [6] = '{
         '{5'b00101, 5'b11111, 1'b0, 0},
         '{5'b00101, 5'b11111, 1'b0, 2},
         '{5'b00101, 5'b11111, 1'b0, 0},
         '{5'b00101, 5'b11111, 1'b0, 2},
         '{5'b00000, 5'b00000, 1'b0, -1},
         '{5'b00000, 5'b00000, 1'b0, -1}};
      logic [N-1:0] g;
      tie = 1'b1;
      foreach (rows[i]) begin
         step(rows[i], g);
         n_checks++;
         if (g !== oh(rows[i].e)) begin
            n_errors++;
            $display("FAIL rr_grant[%0d]: got %b want %b", i, g, oh(rows[i].e));
         end
      end
   endtask

   task automatic test_wormhole_lock();
      row_t rows [8] = '{
         '{5'b01000, 5'b01000, 1'b0, 3},
         '{5'b01010, 5'b00000, 1'b0, 1},
         '{5'b01010, 5'b00000, 1'b0, 1},
         '{5'b01000, 5'b00000, 1'b0, -1},
         '{5'b01010, 5'b00010, 1'b0, 1},
         '{5'b01000, 5'b01000, 1'b0, 3},
         '{5'b00000, 5'b00000, 1'b0, -1},
         '{5'b00000, 5'b00000, 1'b0, -1}};
      logic [N-1:0] g;
      tie = 1'b1;
      foreach (rows[i]) begin
         step(rows[i], g);
         n_checks++;
         if (g !== oh(rows[i].e)) begin
            n_errors++;
            $display("FAIL lock_grant[%0d]: got %b want %b", i, g, oh(rows[i].e));
         end
         if (i == 2 || i == 3 || i == 4) begin
            n_checks++;
            if (bus.locked !== 1'b1) begin n_errors++; $display("FAIL lock_held[%0d]: got %b want 1", i, bus.locked); end
         end
         if (i == 5) begin
            n_checks++;
            if (bus.locked !== 1'b0) begin n_errors++; $display("FAIL lock_released: got %b want 0", bus.locked); end
         end
      end
   endtask

   task automatic test_credit_stall();
      row_t rows [12] = '{
         '{5'b00001, 5'b00000, 1'b0, 0},
         '{5'b00001, 5'b00000, 1'b0, 0},
         '{5'b00001, 5'b00000, 1'b0, -1},
         '{5'b00001, 5'b00000, 1'b1, -1},
         '{5'b00001, 5'b00000, 1'b0, 0},
         '{5'b00001, 5'b00000, 1'b0, -1},
         '{5'b00001, 5'b00000, 1'b1, -1},
         '{5'b00001, 5'b00000, 1'b1, 0},
         '{5'b00001, 5'b00001, 1'b0, 0},
         '{5'b00000, 5'b00000, 1'b1, -1},
         '{5'b00000, 5'b00000, 1'b1, -1},
         '{5'b00000, 5'b00000, 1'b0, -1}};
      logic [N-1:0] g;
      tie = 1'b0;
      foreach (rows[i]) begin
         step(rows[i], g);
         n_checks++;
         if (g !== oh(rows[i].e)) begin
            n_errors++;
            $display("FAIL credit_grant[%0d]: got %b want %b", i, g, oh(rows[i].e));
         end
         if (i == 2) begin
            n_checks += 2;
            if (dut.credits !== 2'd0) begin n_errors++; $display("FAIL credit_empty: got %0d want 0", dut.credits); end
            if (bus.locked !== 1'b1) begin n_errors++; $display("FAIL credit_locked: got %b want 1", bus.locked); end
         end
         if (i == 8) begin
            n_checks++;
            if (dut.credits !== 2'd1) begin n_errors++; $display("FAIL credit_fire_and_return: got %0d want 1", dut.credits); end
         end
         if (i == 9) begin
            n_checks++;
            if (bus.locked !== 1'b0) begin n_errors++; $display("FAIL credit_tail_unlock: got %b want 0", bus.locked); end
         end
         if (i == 11) begin
            n_checks++;
            if (dut.credits !== 2'(CD)) begin n_errors++; $display("FAIL credit_refill: got %0d want %0d", dut.credits, CD); end
         end
      end
   endtask

   task automatic test_overflow();
      row_t rows [3] = '{
         '{5'b00000, 5'b00000, 1'b1, -1},
         '{5'b00000, 5'b00000, 1'b0, -1},
         '{5'b00000, 5'b00000, 1'b0, -1}};
      logic [N-1:0] g;
      tie = 1'b0;
      n_checks++;
      if (bus.credit_overflow !== 1'b0) begin n_errors++; $display("FAIL overflow_early: got %b want 0", bus.credit_overflow); end
      foreach (rows[i]) begin
         step(rows[i], g);
         if (i >= 1) begin
            n_checks += 2;
            if (bus.credit_overflow !== 1'b1) begin n_errors++; $display("FAIL overflow_sticky[%0d]: got %b want 1", i, bus.credit_overflow); end
            if (dut.credits !== 2'(CD)) begin n_errors++; $display("FAIL overflow_credits[%0d]: got %0d want %0d", i, dut.credits, CD); end
         end
      end
   endtask

   task automatic test_reset_mid_packet();
      row_t head = '{5'b00100, 5'b00000, 1'b0, 2};
      row_t idle = '{5'b00000, 5'b00000, 1'b0, -1};
      row_t both = '{5'b10001, 5'b10001, 1'b0, 0};
      row_t only4 = '{5'b10000, 5'b10000, 1'b0, 4};
      logic [N-1:0] g;
      tie = 1'b0;
      step(head, g);
      n_checks++;
      if (g !== oh(2)) begin n_errors++; $display("FAIL mid_head_grant: got %b want %b", g, oh(2)); end
      step(idle, g);
      n_checks++;
      if (bus.locked !== 1'b1) begin n_errors++; $display("FAIL mid_locked: got %b want 1", bus.locked); end
      #1;
      rst_n = 1'b0;
      #1;
      n_checks += 3;
      if (bus.locked !== 1'b0) begin n_errors++; $display("FAIL mid_reset_locked: got %b want 0", bus.locked); end
      if (bus.send_out !== 1'b0) begin n_errors++; $display("FAIL mid_reset_send: got %b want 0", bus.send_out); end
      if (bus.credit_overflow !== 1'b0) begin n_errors++; $display("FAIL mid_reset_overflow: got %b want 0", bus.credit_overflow); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      step(both, g);
      n_checks++;
      if (g !== oh(0)) begin n_errors++; $display("FAIL mid_rr_restart: got %b want %b", g, oh(0)); end
      step(only4, g);
      n_checks++;
      if (g !== oh(4)) begin n_errors++; $display("FAIL mid_grant4: got %b want %b", g, oh(4)); end
      step(idle, g);
      step(idle, g);
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_wormhole_lock();
      test_credit_stall();
      test_overflow();
      test_reset_mid_packet();
      @(negedge clk);
      n_checks++;
      if (sb.size() != 0) begin
         n_errors++;
         $display("FAIL link_missing_sends: got %0d pending want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
